iob_fifo_sync_ctrl: RTL and testbench
=====================================

Name: iob_fifo_sync_ctrl

Overview:
- Synchronous FIFO controller acting as the initiator of a two-port register file interface: it drives the write port (enable, address, data) and the read address, and consumes the combinational read data.
- Provides a push/pop FIFO with occupancy and error flags to the surrounding logic.
- Storage is external; the controller holds only pointers, level, flags and the output data register.
- Depth is 2**ADDR_W.

Parameters:
DATA_W, 21, data word width
ADDR_W, 3, memory address width; FIFO depth = 2**ADDR_W; ADDR_W >= 1

Ports:
clk_i  in  1  clock
arst_i  in  1  asynchronous reset, active-high
cke_i  in  1  clock enable; when 0 all state holds and ext_mem_w_en_o = 0
rst_i  in  1  synchronous soft reset, qualified by cke_i
w_en_i  in  1  push request
w_data_i  in  DATA_W  push data
w_full_o  out  1  FIFO full
r_en_i  in  1  pop request
r_data_o  out  DATA_W  popped data, registered
r_empty_o  out  1  FIFO empty
level_o  out  ADDR_W+1  occupancy, 0..2**ADDR_W
overflow_o  out  1  sticky: push attempted while full
underflow_o  out  1  sticky: pop attempted while empty
ext_mem_w_en_o  out  1  memory write enable
ext_mem_w_addr_o  out  ADDR_W  memory write address
ext_mem_w_data_o  out  DATA_W  memory write data
ext_mem_r_addr_o  out  ADDR_W  memory read address
ext_mem_r_data_i  in  DATA_W  memory read data, combinational from ext_mem_r_addr_o

Behaviour:
- State: wptr, rptr (ADDR_W bits, wrap modulo 2**ADDR_W), level (ADDR_W+1 bits), r_data_o register, overflow/underflow flags.
- arst_i = 1, or (cke_i and rst_i): wptr = rptr = 0, level = 0, r_data_o = 0, overflow_o = underflow_o = 0.
- Derived outputs:
  - r_empty_o = (level == 0); w_full_o = (level == 2**ADDR_W). After reset: empty = 1, full = 0.
- Push accepted: push = cke_i & w_en_i & ~w_full_o & ~rst_i.
  - ext_mem_w_en_o = push (combinational).
  - ext_mem_w_addr_o = wptr; ext_mem_w_data_o = w_data_i.
  - On the clock edge, wptr increments by 1.
- Pop accepted: pop = cke_i & r_en_i & ~r_empty_o & ~rst_i.
  - ext_mem_r_addr_o = rptr at all times.
  - On the clock edge, r_data_o <= ext_mem_r_data_i and rptr increments by 1.
  - Read latency: data is valid on r_data_o 1 cycle after the accepted r_en_i.
  - r_data_o holds its value when no pop occurs.
- Full and empty are evaluated on pre-edge state:
  - Push+pop while full: pop accepted, push rejected (counts as overflow), level decreases by 1.
  - Push+pop while empty: push accepted, pop rejected (counts as underflow), level increases by 1.
  - Push+pop otherwise: both accepted, level unchanged. Read and write addresses differ in this case, so no read-during-write hazard exists.
- Level update: level <= level + push - pop.
- Error flags:
  - overflow_o sets on cke_i & w_en_i & w_full_o.
  - underflow_o sets on cke_i & r_en_i & r_empty_o.
  - Both flags clear only on reset.
- Rejected operations do not change pointers, level or r_data_o.
- Reset mid-operation: in-flight requests in the reset cycle are dropped. Memory contents are untouched but logically discarded.
- Pointer wrap from 2**ADDR_W-1 to 0 is seamless. Full and empty are distinguished by level, not by pointer equality.

Test Plan:
1. Reset then idle, ADDR_W=3, DATA_W=21 -> r_empty_o=1, w_full_o=0, level_o=0, r_data_o=0, flags 0, ext_mem_w_en_o=0.
2. Push 0x000001..0x000008 on 8 consecutive cycles -> ext_mem_w_addr_o 0..7, level_o=8, w_full_o=1. Ninth push 0x1FFFFF -> ext_mem_w_en_o=0, overflow_o=1, level_o stays 8.
3. From full, pop 8 consecutive cycles -> r_data_o = 0x000001..0x000008, each one cycle after its r_en_i; r_empty_o=1. Extra pop -> underflow_o=1, r_data_o stays 0x000008.
4. Wrap: push 5, pop 5, then push 6 -> write addresses 5,6,7,0,1,2. Popping 6 returns the data in order.
5. Simultaneous push+pop: at level 3, level stays 3. At level 0, level becomes 1 and underflow_o=1. At level 8, level becomes 7 and overflow_o=1.
6. cke_i=0 with w_en_i=r_en_i=1 -> no state change, ext_mem_w_en_o=0. Asserting arst_i mid-burst at level 4 -> level_o=0 and flags clear immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/iob_fifo_sync_ctrl_if.sv
// Bundles the FIFO user-side handshake and the register-file port driven by
// the controller. The slave modport is the controller's view.
interface iob_fifo_sync_ctrl_if #(
  parameter int DATA_W = 21,
  parameter int ADDR_W = 3
);
  logic              w_en_i;
  logic [DATA_W-1:0] w_data_i;
  logic              w_full_o;
  logic              r_en_i;
  logic [DATA_W-1:0] r_data_o;
  logic              r_empty_o;
  logic [ADDR_W:0]   level_o;
  logic              overflow_o;
  logic              underflow_o;
  logic              ext_mem_w_en_o;
  logic [ADDR_W-1:0] ext_mem_w_addr_o;
  logic [DATA_W-1:0] ext_mem_w_data_o;
  logic [ADDR_W-1:0] ext_mem_r_addr_o;
  logic [DATA_W-1:0] ext_mem_r_data_i;

  modport slave (
    input  w_en_i, w_data_i, r_en_i, ext_mem_r_data_i,
    output w_full_o, r_data_o, r_empty_o, level_o, overflow_o, underflow_o,
    output ext_mem_w_en_o, ext_mem_w_addr_o, ext_mem_w_data_o, ext_mem_r_addr_o
  );

  modport master (
    output w_en_i, w_data_i, r_en_i, ext_mem_r_data_i,
    input  w_full_o, r_data_o, r_empty_o, level_o, overflow_o, underflow_o,
    input  ext_mem_w_en_o, ext_mem_w_addr_o, ext_mem_w_data_o, ext_mem_r_addr_o
  );
endinterface

// File: rtl/iob_fifo_sync_ctrl.sv
// Synchronous FIFO controller over an external two-port register file.
// Holds pointers, occupancy, sticky error flags and the registered pop data.
module iob_fifo_sync_ctrl #(
  parameter int DATA_W = 21,
  parameter int ADDR_W = 3
) (
  input  logic                 clk_i,
  input  logic                 arst_i,
  input  logic                 cke_i,
  input  logic                 rst_i,
  iob_fifo_sync_ctrl_if.slave  bus
);
  localparam logic [ADDR_W-1:0] PTR_ONE = 1;
  localparam logic [ADDR_W:0]   LVL_ONE = 1;
  localparam logic [ADDR_W:0]   DEPTH   = LVL_ONE << ADDR_W;

  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] rptr_q, rptr_d;
  logic [ADDR_W:0]   level_q, level_d;
  logic [DATA_W-1:0] r_data_q, r_data_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic full, empty, push, pop;

  // Full/empty come from the level, so pointer equality never needs decoding.
  assign full  = (level_q == DEPTH);
  assign empty = (level_q == '0);
  assign push  = cke_i & bus.w_en_i & ~full  & ~rst_i;
  assign pop   = cke_i & bus.r_en_i & ~empty & ~rst_i;

  assign bus.w_full_o         = full;
  assign bus.r_empty_o        = empty;
  assign bus.level_o          = level_q;
  assign bus.r_data_o         = r_data_q;
  assign bus.overflow_o       = overflow_q;
  assign bus.underflow_o      = underflow_q;
  assign bus.ext_mem_w_en_o   = push;
  assign bus.ext_mem_w_addr_o = wptr_q;
  assign bus.ext_mem_w_data_o = bus.w_data_i;
  assign bus.ext_mem_r_addr_o = rptr_q;

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    level_d     = level_q;
    r_data_d    = r_data_q;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;
    if (cke_i) begin
      if (rst_i) begin
        wptr_d      = '0;
        rptr_d      = '0;
        level_d     = '0;
        r_data_d    = '0;
        overflow_d  = 1'b0;
        underflow_d = 1'b0;
      end else begin
        if (push) wptr_d = wptr_q + PTR_ONE;
        if (pop) begin
          rptr_d   = rptr_q + PTR_ONE;
          r_data_d = bus.ext_mem_r_data_i;
        end
        case ({push, pop})
          2'b10:   level_d = level_q + LVL_ONE;
          2'b01:   level_d = level_q - LVL_ONE;
          default: level_d = level_q;
        endcase
        if (bus.w_en_i && full)  overflow_d  = 1'b1;
        if (bus.r_en_i && empty) underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      level_q     <= '0;
      r_data_q    <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      level_q     <= level_d;
      r_data_q    <= r_data_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end
endmodule

// File: tb/tb_iob_fifo_sync_ctrl.sv
// Directed bench for iob_fifo_sync_ctrl with a behavioural register file
// attached to the memory port; expected values are hand-derived constants.
module tb_iob_fifo_sync_ctrl;
  localparam int DATA_W = 21;
  localparam int ADDR_W = 3;

  logic clk;
  logic arst;
  logic cke;
  logic rst;
  int   testCount;
  int   failCount;

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  iob_fifo_sync_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  iob_fifo_sync_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i  (clk),
    .arst_i (arst),
    .cke_i  (cke),
    .rst_i  (rst),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file: synchronous write, combinational read.
  always @(posedge clk) begin
    if (bus.ext_mem_w_en_o) mem[bus.ext_mem_w_addr_o] <= bus.ext_mem_w_data_o;
  end
  assign bus.ext_mem_r_data_i = mem[bus.ext_mem_r_addr_o];

  task automatic applyStimulus(input logic wen, input logic [DATA_W-1:0] wdata, input logic ren);
    bus.w_en_i   = wen;
    bus.w_data_i = wdata;
    bus.r_en_i   = ren;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      $error("[TB] check %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = '0;
    arst = 1'b1;
    cke  = 1'b1;
    rst  = 1'b0;
    applyStimulus(1'b0, '0, 1'b0);
    tick();
    tick();
    arst = 1'b0;
    #1;

    // Reset and idle
    checkOutput("rst_empty", {31'd0, bus.r_empty_o}, 32'd1);
    checkOutput("rst_full", {31'd0, bus.w_full_o}, 32'd0);
    checkOutput("rst_level", {28'd0, bus.level_o}, 32'd0);
    checkOutput("rst_rdata", {11'd0, bus.r_data_o}, 32'd0);
    checkOutput("rst_ovf", {31'd0, bus.overflow_o}, 32'd0);
    checkOutput("rst_unf", {31'd0, bus.underflow_o}, 32'd0);
    checkOutput("rst_wen", {31'd0, bus.ext_mem_w_en_o}, 32'd0);
    tick();

    // Fill to full, then overflow
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, DATA_W'(i + 1), 1'b0);
      #1;
      checkOutput("fill_wen", {31'd0, bus.ext_mem_w_en_o}, 32'd1);
      checkOutput("fill_waddr", {29'd0, bus.ext_mem_w_addr_o}, 32'(i));
      checkOutput("fill_wdata", {11'd0, bus.ext_mem_w_data_o}, 32'(i + 1));
      tick();
      checkOutput("fill_level", {28'd0, bus.level_o}, 32'(i + 1));
    end
    checkOutput("fill_full", {31'd0, bus.w_full_o}, 32'd1);
    checkOutput("fill_empty", {31'd0, bus.r_empty_o}, 32'd0);
    applyStimulus(1'b1, 21'h1FFFFF, 1'b0);
    #1;
    checkOutput("ovf_wen", {31'd0, bus.ext_mem_w_en_o}, 32'd0);
    tick();
    checkOutput("ovf_flag", {31'd0, bus.overflow_o}, 32'd1);
    checkOutput("ovf_level", {28'd0, bus.level_o}, 32'd8);

    // Drain in order, then underflow
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, '0, 1'b1);
      #1;
      checkOutput("drain_raddr", {29'd0, bus.ext_mem_r_addr_o}, 32'(i));
      tick();
      checkOutput("drain_rdata", {11'd0, bus.r_data_o}, 32'(i + 1));
      checkOutput("drain_level", {28'd0, bus.level_o}, 32'(7 - i));
    end
    checkOutput("drain_empty", {31'd0, bus.r_empty_o}, 32'd1);
    applyStimulus(1'b0, '0, 1'b1);
    tick();
    checkOutput("unf_flag", {31'd0, bus.underflow_o}, 32'd1);
    checkOutput("unf_rdata", {11'd0, bus.r_data_o}, 32'h8);
    checkOutput("unf_level", {28'd0, bus.level_o}, 32'd0);
    checkOutput("ovf_sticky", {31'd0, bus.overflow_o}, 32'd1);

    // Soft reset drops the push presented in the same cycle
    rst = 1'b1;
    applyStimulus(1'b1, 21'h0ABCDE, 1'b0);
    #1;
    checkOutput("srst_wen", {31'd0, bus.ext_mem_w_en_o}, 32'd0);
    tick();
    rst = 1'b0;
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("srst_level", {28'd0, bus.level_o}, 32'd0);
    checkOutput("srst_ovf", {31'd0, bus.overflow_o}, 32'd0);
    checkOutput("srst_unf", {31'd0, bus.underflow_o}, 32'd0);
    checkOutput("srst_rdata", {11'd0, bus.r_data_o}, 32'd0);

    // Wrap: push 5, pop 5, push 6 across the address boundary, pop 6
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, DATA_W'(32'h100 + i), 1'b0);
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, '0, 1'b1);
      tick();
      checkOutput("wrap_pop5", {11'd0, bus.r_data_o}, 32'h100 + 32'(i));
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, DATA_W'(32'h200 + i), 1'b0);
      #1;
      checkOutput("wrap_waddr", {29'd0, bus.ext_mem_w_addr_o}, 32'((5 + i) % 8));
      tick();
    end
    checkOutput("wrap_level", {28'd0, bus.level_o}, 32'd6);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, '0, 1'b1);
      tick();
      checkOutput("wrap_pop6", {11'd0, bus.r_data_o}, 32'h200 + 32'(i));
    end
    checkOutput("wrap_empty", {31'd0, bus.r_empty_o}, 32'd1);

    // Simultaneous push+pop at level 3
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, DATA_W'(32'h300 + i), 1'b0);
      tick();
    end
    applyStimulus(1'b1, 21'h0003AA, 1'b1);
    tick();
    checkOutput("pp3_level", {28'd0, bus.level_o}, 32'd3);
    checkOutput("pp3_rdata", {11'd0, bus.r_data_o}, 32'h300);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, '0, 1'b1);
      tick();
    end
    checkOutput("pp3_last", {11'd0, bus.r_data_o}, 32'h3AA);
    checkOutput("pp3_drained", {28'd0, bus.level_o}, 32'd0);

    // Simultaneous push+pop at level 0
    applyStimulus(1'b1, 21'h0003BB, 1'b1);
    #1;
    checkOutput("pp0_wen", {31'd0, bus.ext_mem_w_en_o}, 32'd1);
    tick();
    checkOutput("pp0_level", {28'd0, bus.level_o}, 32'd1);
    checkOutput("pp0_unf", {31'd0, bus.underflow_o}, 32'd1);
    checkOutput("pp0_rdata", {11'd0, bus.r_data_o}, 32'h3AA);

    // Simultaneous push+pop at level 8
    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b1, DATA_W'(32'h400 + i), 1'b0);
      tick();
    end
    checkOutput("pp8_full", {31'd0, bus.w_full_o}, 32'd1);
    applyStimulus(1'b1, 21'h0005CC, 1'b1);
    #1;
    checkOutput("pp8_wen", {31'd0, bus.ext_mem_w_en_o}, 32'd0);
    tick();
    checkOutput("pp8_level", {28'd0, bus.level_o}, 32'd7);
    checkOutput("pp8_ovf", {31'd0, bus.overflow_o}, 32'd1);
    checkOutput("pp8_rdata", {11'd0, bus.r_data_o}, 32'h3BB);

    // Clock enable low freezes everything
    cke = 1'b0;
    applyStimulus(1'b1, 21'h0006DD, 1'b1);
    #1;
    checkOutput("cke_wen", {31'd0, bus.ext_mem_w_en_o}, 32'd0);
    tick();
    checkOutput("cke_level", {28'd0, bus.level_o}, 32'd7);
    checkOutput("cke_rdata", {11'd0, bus.r_data_o}, 32'h3BB);
    cke = 1'b1;

    // Async reset mid-burst at level 4
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, '0, 1'b1);
      tick();
    end
    checkOutput("ar_pre_level", {28'd0, bus.level_o}, 32'd4);
    checkOutput("ar_pre_rdata", {11'd0, bus.r_data_o}, 32'h402);
    applyStimulus(1'b1, 21'h0007EE, 1'b1);
    arst = 1'b1;
    #1;
    checkOutput("ar_level", {28'd0, bus.level_o}, 32'd0);
    checkOutput("ar_ovf", {31'd0, bus.overflow_o}, 32'd0);
    checkOutput("ar_unf", {31'd0, bus.underflow_o}, 32'd0);
    checkOutput("ar_empty", {31'd0, bus.r_empty_o}, 32'd1);
    checkOutput("ar_rdata", {11'd0, bus.r_data_o}, 32'd0);
    applyStimulus(1'b0, '0, 1'b0);
    tick();
    arst = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end
endmodule
